// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch control slice: time-word and BCD digit
// widths, the lap counter saturation value, the FSM state encodings and the
// single-digit BCD increment helper.
package stopwatch_pkg;

  localparam int TIME_W  = 36;
  localparam int DIGIT_W = 4;
  localparam int LAP_MAX = 9;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'b00;
  localparam state_t ST_RUN     = 2'b01;
  localparam state_t ST_PAUSE   = 2'b10;
  localparam state_t ST_LAPVIEW = 2'b11;

  // One BCD digit step: 9 wraps to 0, anything else counts up by one.
  function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/lap_register.sv
// lap_register
// Holds the most recently captured lap time and a saturating BCD lap count.
// Ports:
//   clk_i, reset       : clock and asynchronous active-high reset
//   load_i             : capture time_i and bump the lap count
//   clear_i            : zero both the lap time and the lap count
//   time_i             : live BCD time from the counter
//   lap_time_o         : last captured lap time
//   lap_cnt_o          : BCD lap count, 0..LAP_MAX
module lap_register
  import stopwatch_pkg::*;
#(
  parameter int TIME_W  = stopwatch_pkg::TIME_W,
  parameter int LAP_MAX = stopwatch_pkg::LAP_MAX
) (
  input  logic               clk_i,
  input  logic               reset,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [TIME_W-1:0]  time_i,
  output logic [TIME_W-1:0]  lap_time_o,
  output logic [DIGIT_W-1:0] lap_cnt_o
);

  localparam logic [DIGIT_W-1:0] LapMax = DIGIT_W'(LAP_MAX);

  logic [TIME_W-1:0]  lap_time_q, lap_time_d;
  logic [DIGIT_W-1:0] lap_cnt_q,  lap_cnt_d;

  // Clear wins over load. Once the count reaches LapMax a lap still
  // refreshes the captured time but the count holds.
  always_comb begin
    lap_time_d = lap_time_q;
    lap_cnt_d  = lap_cnt_q;
    if (clear_i) begin
      lap_time_d = '0;
      lap_cnt_d  = '0;
    end else if (load_i) begin
      lap_time_d = time_i;
      if (lap_cnt_q < LapMax) begin
        lap_cnt_d = bcd_inc(lap_cnt_q);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      lap_time_q <= '0;
      lap_cnt_q  <= '0;
    end else begin
      lap_time_q <= lap_time_d;
      lap_cnt_q  <= lap_cnt_d;
    end
  end

  assign lap_time_o = lap_time_q;
  assign lap_cnt_o  = lap_cnt_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Control FSM for the BCD stopwatch. Converts clean one-cycle button pulses
// into run-enable and clear controls for the time counter, captures lap times
// and selects live or lap time for the display.
// Ports:
//   clk_i, reset                    : clock and asynchronous active-high reset
//   start_i, stop_i, lap_i, clear_i : debounced single-cycle pulses
//   time_i                          : live BCD time from the counter
//   run_o                           : counter enable level
//   count_clr_o                     : one-cycle clear strobe to the counter
//   lap_time_o, lap_cnt_o           : last lap time and BCD lap count
//   show_lap_o                      : display select, 1 = lap time
//   state_o                         : current FSM state for debug/LEDs
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TIME_W  = stopwatch_pkg::TIME_W,
  parameter int LAP_MAX = stopwatch_pkg::LAP_MAX
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              lap_i,
  input  logic              clear_i,
  input  logic [TIME_W-1:0] time_i,
  output logic              run_o,
  output logic              count_clr_o,
  output logic [TIME_W-1:0] lap_time_o,
  output logic [3:0]        lap_cnt_o,
  output logic              show_lap_o,
  output logic [1:0]        state_o
);

  state_t state_q, state_d;
  logic   run_q, show_lap_q, clr_q, clr_d;
  logic   lap_load, lap_clear;

  // Next-state logic. Each state only looks at the pulses that are legal in
  // it, tested in stop > lap > start > clear order, so a simultaneous pulse
  // that is illegal here can never mask a legal lower-priority one.
  always_comb begin
    state_d   = state_q;
    clr_d     = 1'b0;
    lap_load  = 1'b0;
    lap_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
        end else if (clear_i) begin
          clr_d     = 1'b1;
          lap_clear = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_PAUSE;
        end else if (lap_i) begin
          state_d  = ST_LAPVIEW;
          lap_load = 1'b1;
        end
      end
      ST_LAPVIEW: begin
        if (stop_i) begin
          state_d = ST_PAUSE;
        end else if (lap_i) begin
          lap_load = 1'b1;
        end else if (start_i) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (start_i) begin
          state_d = ST_RUN;
        end else if (clear_i) begin
          state_d   = ST_IDLE;
          clr_d     = 1'b1;
          lap_clear = 1'b1;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with state_o one cycle after the pulse. Reset drops run and show-lap at
  // once and never raises the clear strobe.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      run_q      <= 1'b0;
      show_lap_q <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= (state_d == ST_RUN) || (state_d == ST_LAPVIEW);
      show_lap_q <= (state_d == ST_LAPVIEW);
      clr_q      <= clr_d;
    end
  end

  lap_register #(
    .TIME_W (TIME_W),
    .LAP_MAX(LAP_MAX)
  ) u_lap_register (
    .clk_i     (clk_i),
    .reset     (reset),
    .load_i    (lap_load),
    .clear_i   (lap_clear),
    .time_i    (time_i),
    .lap_time_o(lap_time_o),
    .lap_cnt_o (lap_cnt_o)
  );

  assign run_o       = run_q;
  assign show_lap_o  = show_lap_q;
  assign count_clr_o = clr_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
// Directed bench for stopwatch_ctrl with a behavioural model of the
// stopwatch described as "idle / running / viewing a lap" flags plus an
// integer lap count, compared against the DUT on every falling edge.
module tb_stopwatch_ctrl;

  logic        clk;
  logic        reset;
  logic        start, stop, lap, clr;
  logic [35:0] timeIn;
  logic        runO, clrO, showLapO;
  logic [35:0] lapTimeO;
  logic [3:0]  lapCntO;
  logic [1:0]  stateO;

  int checks = 0;
  int errors = 0;

  bit          mIdle, mRunning, mViewing, mClr;
  int          mLapCnt;
  logic [35:0] mLapTime;

  stopwatch_ctrl dut (
    .clk_i      (clk),
    .reset      (reset),
    .start_i    (start),
    .stop_i     (stop),
    .lap_i      (lap),
    .clear_i    (clr),
    .time_i     (timeIn),
    .run_o      (runO),
    .count_clr_o(clrO),
    .lap_time_o (lapTimeO),
    .lap_cnt_o  (lapCntO),
    .show_lap_o (showLapO),
    .state_o    (stateO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: the watch is idle, paused (not idle, not running),
  // running live, or running with the display frozen on a lap.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mIdle = 1; mRunning = 0; mViewing = 0; mClr = 0;
      mLapCnt = 0; mLapTime = '0;
    end else begin
      mClr = 0;
      if (mIdle) begin
        if (start) begin
          mIdle = 0; mRunning = 1;
        end else if (clr) begin
          mClr = 1; mLapCnt = 0; mLapTime = '0;
        end
      end else if (!mRunning) begin
        if (start) begin
          mRunning = 1;
        end else if (clr) begin
          mIdle = 1; mClr = 1; mLapCnt = 0; mLapTime = '0;
        end
      end else begin
        if (stop) begin
          mRunning = 0; mViewing = 0;
        end else if (lap) begin
          mViewing = 1; mLapTime = timeIn;
          mLapCnt = (mLapCnt + 1 > 9) ? 9 : mLapCnt + 1;
        end else if (start && mViewing) begin
          mViewing = 0;
        end
      end
    end
  end

  task automatic checkValue(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [1:0] expState;
    expState = mIdle ? 2'b00 : (!mRunning ? 2'b10 : (mViewing ? 2'b11 : 2'b01));
    checkValue("model_state", {34'd0, stateO}, {34'd0, expState});
    checkValue("model_run", {35'd0, runO}, {35'd0, mRunning});
    checkValue("model_show_lap", {35'd0, showLapO}, {35'd0, mViewing});
    checkValue("model_count_clr", {35'd0, clrO}, {35'd0, mClr});
    checkValue("model_lap_cnt", {32'd0, lapCntO}, 36'(mLapCnt));
    checkValue("model_lap_time", lapTimeO, mLapTime);
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) checkOutput();

  task automatic applyStimulus(input logic s, input logic p, input logic l,
                               input logic c, input logic [35:0] t);
    @(negedge clk);
    start = s; stop = p; lap = l; clr = c; timeIn = t;
  endtask

  initial begin
    reset = 1'b1;
    start = 0; stop = 0; lap = 0; clr = 0; timeIn = '0;
    repeat (2) @(negedge clk);
    checkValue("reset_run", {35'd0, runO}, 36'd0);
    checkValue("reset_state", {34'd0, stateO}, 36'd0);
    checkValue("reset_lap_cnt", {32'd0, lapCntO}, 36'd0);
    reset = 1'b0;

    // Start from idle.
    applyStimulus(1, 0, 0, 0, 36'h0);
    applyStimulus(0, 0, 0, 0, 36'h0);
    checkValue("start_run", {35'd0, runO}, 36'd1);
    checkValue("start_state", {34'd0, stateO}, 36'd1);
    checkValue("start_show_lap", {35'd0, showLapO}, 36'd0);

    // First lap capture.
    applyStimulus(0, 0, 1, 0, 36'h0_0001_2345);
    applyStimulus(0, 0, 0, 0, 36'h0_0001_2346);
    checkValue("lap1_time", lapTimeO, 36'h0_0001_2345);
    checkValue("lap1_cnt", {32'd0, lapCntO}, 36'd1);
    checkValue("lap1_show", {35'd0, showLapO}, 36'd1);
    checkValue("lap1_run", {35'd0, runO}, 36'd1);

    // Ten back-to-back laps saturate the count at 9.
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0, 36'h0_0000_0100 + 36'(i));
    applyStimulus(0, 0, 0, 0, 36'h0);
    checkValue("sat_cnt", {32'd0, lapCntO}, 36'd9);
    checkValue("sat_time", lapTimeO, 36'h0_0000_0109);

    // Clear ignored in LAPVIEW, start returns to live display.
    applyStimulus(0, 0, 0, 1, 36'h0);
    applyStimulus(1, 0, 0, 1, 36'h0);
    applyStimulus(0, 0, 0, 0, 36'h0);
    checkValue("lapview_start_state", {34'd0, stateO}, 36'd1);

    // Clear and start ignored in RUN; stop beats lap.
    applyStimulus(1, 0, 0, 1, 36'h0);
    applyStimulus(0, 1, 1, 0, 36'h0_0000_7777);
    applyStimulus(0, 0, 0, 0, 36'h0);
    checkValue("stoplap_state", {34'd0, stateO}, 36'd2);
    checkValue("stoplap_run", {35'd0, runO}, 36'd0);
    checkValue("stoplap_cnt", {32'd0, lapCntO}, 36'd9);

    // Lap ignored in PAUSE, clear returns to IDLE with a single strobe.
    applyStimulus(0, 0, 1, 0, 36'h0_0000_8888);
    applyStimulus(0, 0, 0, 1, 36'h0);
    applyStimulus(0, 0, 0, 0, 36'h0);
    checkValue("clear_strobe", {35'd0, clrO}, 36'd1);
    checkValue("clear_cnt", {32'd0, lapCntO}, 36'd0);
    checkValue("clear_time", lapTimeO, 36'h0);
    checkValue("clear_state", {34'd0, stateO}, 36'd0);
    applyStimulus(0, 0, 0, 0, 36'h0);
    checkValue("clear_strobe_end", {35'd0, clrO}, 36'd0);

    // In IDLE: stop/lap ignored, clear strobes, start beats clear.
    applyStimulus(0, 1, 1, 0, 36'h0_0000_0042);
    applyStimulus(0, 0, 0, 1, 36'h0);
    applyStimulus(1, 0, 0, 1, 36'h0);
    applyStimulus(0, 0, 0, 0, 36'h0);
    checkValue("idle_start_clr", {35'd0, clrO}, 36'd0);

    // Lap, stop from LAPVIEW, restart from PAUSE, lap again.
    applyStimulus(0, 0, 1, 0, 36'h0_0000_0555);
    applyStimulus(0, 1, 0, 0, 36'h0);
    applyStimulus(1, 0, 0, 0, 36'h0);
    applyStimulus(0, 0, 1, 0, 36'h0_0000_0666);
    applyStimulus(0, 0, 0, 0, 36'h0);
    checkValue("relap_cnt", {32'd0, lapCntO}, 36'd2);

    // Asynchronous reset between edges while viewing a lap.
    #2 reset = 1'b1;
    #1;
    checkValue("async_run", {35'd0, runO}, 36'd0);
    checkValue("async_show", {35'd0, showLapO}, 36'd0);
    checkValue("async_state", {34'd0, stateO}, 36'd0);
    checkValue("async_cnt", {32'd0, lapCntO}, 36'd0);
    checkValue("async_time", lapTimeO, 36'h0);
    checkValue("async_clr", {35'd0, clrO}, 36'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(1, 0, 0, 0, 36'h0);
    repeat (3) applyStimulus(0, 0, 0, 0, 36'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
